sar_search: RTL and testbench

//  Successive-approximation search controller; the consumer end of the magnitude-comparator interface.

---
 rtl/sar_search_if.sv | 28 ++
 rtl/sar_search.sv | 115 +++++++++++
 tb/tb_sar_search.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sar_search_if.sv
// Handshake between the search controller, its issuing FSM and the
// external magnitude comparator (a = guess, b = target).
interface sar_search_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             cmp_eq;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic             found;
  logic             err;
  logic [WIDTH-1:0] result;

  // Control FSM plus comparator side
  modport master (
    output start, cmp_gt, cmp_lt, cmp_eq,
    input  guess, busy, done, found, err, result
  );

  // Search controller side
  modport slave (
    input  start, cmp_gt, cmp_lt, cmp_eq,
    output guess, busy, done, found, err, result
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search controller: drives a candidate into an
// external comparator and converges MSB-first on the target value.
module sar_search #(
  parameter int unsigned WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  sar_search_if.slave   bus
);

  localparam int unsigned    IDXW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic             err_q, err_d;
  logic [2:0]       cmp;
  logic             legal;

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      guess_q  <= '0;
      idx_q    <= IDX_TOP;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  // Next-state and next-output logic for the search sequence
  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    idx_d    = idx_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    found_d  = found_q;
    err_d    = err_q;
    cmp      = {bus.cmp_gt, bus.cmp_lt, bus.cmp_eq};
    legal    = (cmp == 3'b100) || (cmp == 3'b010) || (cmp == 3'b001);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d            = S_SEARCH;
          guess_d            = '0;
          guess_d[WIDTH-1]   = 1'b1;
          idx_d              = IDX_TOP;
          result_d           = '0;
          busy_d             = 1'b1;
          done_d             = 1'b0;
          found_d            = 1'b0;
          err_d              = 1'b0;
        end
      end
      S_SEARCH, S_CHECK: begin
        // Any terminating compare (illegal code, match, or the final CHECK)
        // shares one exit path; only the flag/result values differ.
        if (!legal || bus.cmp_eq || (state_q == S_CHECK)) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          found_d  = legal && bus.cmp_eq;
          err_d    = !legal;
          result_d = (legal && bus.cmp_eq) ? guess_q : '0;
        end else begin
          if (bus.cmp_gt) begin
            guess_d[idx_q] = 1'b0;
          end
          if (idx_q != '0) begin
            guess_d[idx_q - 1'b1] = 1'b1;
            idx_d                 = idx_q - 1'b1;
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.guess  = guess_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.found  = found_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: a behavioural comparator against a
// fixed target, plus a prefix-based model of the expected search trace.
module tb_sar_search;

  logic        clk;
  logic        rst;
  logic [15:0] target;
  logic        bad_cmp;
  logic [2:0]  bad_pat;
  int          total;
  int          nbad;

  sar_search_if #(.WIDTH(16)) bus ();

  sar_search #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator: a = guess, b = target, optionally overridden by an illegal code
  assign bus.cmp_gt = bad_cmp ? bad_pat[2] : (bus.guess > target);
  assign bus.cmp_lt = bad_cmp ? bad_pat[1] : (bus.guess < target);
  assign bus.cmp_eq = bad_cmp ? bad_pat[0] : (bus.guess == target);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Compares needed: the guess at step j is the target's top j bits plus a
  // trial bit at 15-j, so it first equals the target when the trial bit
  // lands on the target's lowest set bit. A zero target needs the extra check.
  function automatic int exp_ncmp(input logic [15:0] t);
    for (int b = 0; b < 16; b++)
      if (t[b]) return 16 - b;
    return 17;
  endfunction

  function automatic logic [15:0] exp_guess(input logic [15:0] t, input int j);
    logic [31:0] keep;
    logic [15:0] trial;
    if (j >= 16) return t;
    keep  = 32'h0000_FFFF << (16 - j);
    trial = 16'h1 << (15 - j);
    return (t & keep[15:0]) | trial;
  endfunction

  // One search: fault_at/rst_at select the 0-based compare at which an
  // illegal code is injected or reset is asserted (-1 = never).
  task automatic run(input logic [15:0] tgt, input int fault_at, input logic [2:0] pat,
                     input int rst_at, input bit poke);
    int n;
    int cyc;
    bit e_err;
    target  = tgt;
    bad_pat = pat;
    bad_cmp = 1'b0;
    n       = exp_ncmp(tgt);
    e_err   = (fault_at >= 0) && (fault_at < n);
    if (e_err) n = fault_at + 1;

    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (rst_at >= 0 && cyc == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_guess", 32'(bus.guess), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk) rst = 1'b0;
        return;
      end
      chk("guess", 32'(bus.guess), 32'(exp_guess(tgt, cyc)));
      chk("busy", 32'(bus.busy), 32'd1);
      bus.start = (poke && cyc == 3);
      bad_cmp   = (cyc == fault_at);
      @(negedge clk);
      cyc++;
    end
    bad_cmp   = 1'b0;
    bus.start = 1'b0;

    chk("latency", 32'(cyc), 32'(n));
    chk("done", 32'(bus.done), 32'd1);
    chk("busy_end", 32'(bus.busy), 32'd0);
    chk("err", 32'(bus.err), 32'(e_err));
    chk("found", 32'(bus.found), 32'(!e_err));
    chk("result", 32'(bus.result), e_err ? 32'd0 : 32'(tgt));
    chk("guess_hold", 32'(bus.guess), 32'(exp_guess(tgt, n - 1)));

    if (poke) begin
      repeat (3) @(negedge clk);
      chk("poke_done", 32'(bus.done), 32'd1);
      chk("poke_busy", 32'(bus.busy), 32'd0);
      chk("poke_result", 32'(bus.result), 32'(tgt));
    end
  endtask

  initial begin
    logic [2:0] illegal [4];
    logic [15:0] t;
    int f;
    illegal[0] = 3'b110;
    illegal[1] = 3'b000;
    illegal[2] = 3'b011;
    illegal[3] = 3'b111;
    total     = 0;
    nbad      = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    target    = '0;
    bad_cmp   = 1'b0;
    bad_pat   = 3'b000;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_guess", 32'(bus.guess), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_found", 32'(bus.found), 32'd0);
    chk("reset_err", 32'(bus.err), 32'd0);
    chk("reset_result", 32'(bus.result), 32'd0);

    run(16'h8000, -1, 3'b000, -1, 1'b0);
    run(16'h0000, -1, 3'b000, -1, 1'b0);
    run(16'hFFFF, -1, 3'b000, -1, 1'b0);
    run(16'h1234, -1, 3'b000, -1, 1'b0);
    run(16'h1234, -1, 3'b000, -1, 1'b1);
    run(16'h1234,  2, 3'b110, -1, 1'b0);
    run(16'h1234, -1, 3'b000,  5, 1'b0);
    run(16'h1234, -1, 3'b000, -1, 1'b0);
    run(16'h0001,  0, 3'b000, -1, 1'b0);
    run(16'h0000, 16, 3'b111, -1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      t = 16'($urandom);
      f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16)) : -1;
      run(t, f, illegal[$urandom_range(0, 3)], -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
